// File: rtl/approx_mul16_seq.sv
// approx_mul16_seq: 16x16 product sequenced over one shared approx_8x8 core, exact or carry-free OR merge.
// Optional macro APPROX_MUL16_SEQ_SKIP_EN skips partial products that have a zero operand byte.

module approx_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        precise_en,
  output logic [15:0] y
);
  // Approximate mode ORs the shifted partial-product rows instead of adding them.
  always_comb begin
    y = '0;
    if (precise_en) begin
      y = {8'd0, a} * {8'd0, b};
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (b[i]) y = y | ({8'd0, a} << i);
      end
    end
  end
endmodule

module approx_mul16_seq #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_precise,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // MUL   | one byte partial product accumulated per cycle
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      a_q, b_q;
  logic             precise_q;
  logic [TAG_W-1:0] tag_q;
  logic [1:0]       step;
  logic [3:0]       live_q;
  logic [31:0]      acc;
  logic [31:0]      y_q;
  logic [TAG_W-1:0] otag_q;

  logic [3:0]  in_live;
  logic [1:0]  first_step, next_step;
  logic        has_next;
  logic [7:0]  core_a, core_b;
  logic [15:0] core_y;
  logic [31:0] pp, acc_nxt;

  // Bit k set means step k contributes a nonzero partial product and must be run.
`ifdef APPROX_MUL16_SEQ_SKIP_EN
  assign in_live = {(|in_a[15:8]) & (|in_b[15:8]),
                    (|in_a[7:0])  & (|in_b[15:8]),
                    (|in_a[15:8]) & (|in_b[7:0]),
                    (|in_a[7:0])  & (|in_b[7:0])};
`else
  assign in_live = 4'hF;
`endif

  always_comb begin
    first_step = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (in_live[i]) first_step = 2'(i);
    end
    next_step = step;
    has_next  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (live_q[i] && (i > int'(step))) begin
        next_step = 2'(i);
        has_next  = 1'b1;
      end
    end
  end

  // step[0] selects the high byte of a, step[1] the high byte of b.
  assign core_a = step[0] ? a_q[15:8] : a_q[7:0];
  assign core_b = step[1] ? b_q[15:8] : b_q[7:0];

  approx_8x8 u_core (
    .a          (core_a),
    .b          (core_b),
    .precise_en (precise_q),
    .y          (core_y)
  );

  always_comb begin
    case (step)
      2'd0:    pp = {16'd0, core_y};
      2'd3:    pp = {core_y, 16'd0};
      default: pp = {8'd0, core_y, 8'd0};
    endcase
    acc_nxt = precise_q ? (acc + pp) : (acc | pp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (in_live == 4'd0) ? DONE : MUL;
      MUL:     if (!has_next) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      precise_q <= 1'b0;
      tag_q     <= '0;
      step      <= 2'd0;
      live_q    <= 4'd0;
      acc       <= '0;
      y_q       <= '0;
      otag_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= in_a;
            b_q       <= in_b;
            precise_q <= in_precise;
            tag_q     <= in_tag;
            live_q    <= in_live;
            step      <= first_step;
            acc       <= '0;
            if (in_live == 4'd0) begin
              y_q    <= '0;
              otag_q <= in_tag;
            end
          end
        end
        MUL: begin
          acc  <= acc_nxt;
          step <= next_step;
          if (!has_next) begin
            y_q    <= acc_nxt;
            otag_q <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_y     = y_q;
  assign out_tag   = otag_q;
endmodule

// File: doc/approx_mul16_seq.md
Name: approx_mul16_seq

Overview:
- Multi-cycle sequencer that computes a 16x16 product by time-multiplexing a single approx_8x8 instance over four byte-partial-products.
- Accumulates the partials exactly (precise mode) or with carry-free OR merging (approximate mode).
- Trades the area of four 8x8 cores for 4-cycle throughput in area-constrained datapaths.
- Valid/ready on both sides; one transaction in flight.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to result, unmodified.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  16  multiplicand.
- in_b  in  16  multiplier.
- in_precise  in  1  1 = exact accumulation; 0 = approximate.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_y  out  32  product.
- out_tag  out  TAG_W  tag of this result.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, step=0, acc=0, out_valid=0, out_y=0, out_tag=0, busy=0, in_ready=1 after reset deasserts.
- Clear mid-operation: rst mid-operation aborts the in-flight transaction; no result is produced.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (cycle T), latch a, b, precise and tag; clear acc; step=0; go to MUL.
- MUL:
  - in_ready=0. One step per cycle.
  - The 8x8 core is driven with the latched precise bit as its precise_en.
  - Step order and shifts:
    - 0: a[7:0]*b[7:0], shift 0.
    - 1: a[15:8]*b[7:0], shift 8.
    - 2: a[7:0]*b[15:8], shift 8.
    - 3: a[15:8]*b[15:8], shift 16.
  - pp = core output zero-extended to 32 bits, shifted.
  - precise=1: acc <= acc + pp (32-bit, no overflow possible).
  - precise=0: acc <= acc | pp (no carry propagation).
  - After step 3: out_y <= final acc, out_tag <= tag, go to DONE.
- DONE:
  - out_valid=1.
  - out_y and out_tag are held stable while out_ready=0.
  - On out_ready=1, go to IDLE; out_valid drops next cycle. out_y keeps its last value.
- Latency: request at T -> out_valid at T+5. Throughput: one result per 6 cycles with out_ready tied high (IDLE costs one cycle).
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- in_valid while busy: ignored (in_ready=0). The requester must hold in_valid/data until accepted.
- Input changes after acceptance: in_a/in_b/in_precise changes have no effect on the in-flight operation.
- busy=1 in MUL and DONE.

Optional Feature:
- Macro: APPROX_MUL16_SEQ_SKIP_EN.
- Defined:
  - A step whose two operand bytes include a zero byte is skipped without consuming a cycle. Its pp is 0, so the result is identical.
  - The FSM advances directly to the next non-skipped step.
  - Latency = T + 1 + (number of non-skipped steps).
  - If all steps are skipped (in_a==0 or in_b==0): MUL is bypassed, DONE is entered at T+1 with out_y=0.
- Undefined: always four MUL cycles; latency T+5.

Test Plan:
- Precise full-scale: a=0xFFFF, b=0xFFFF, precise=1, tag=0x5 -> out_y=0xFFFE0001, out_tag=0x5, out_valid at T+5 (skip undefined).
- Approximate merge: a=0x0101, b=0x0101. precise=1 -> out_y=0x00010201; precise=0 -> out_y=0x00010101 (OR of overlapping shift-8 partials).
- Core approximation passthrough: a=0x0003, b=0x0003. precise=1 -> out_y=9; precise=0 -> out_y=7.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_y/out_tag stable, in_ready=0 throughout. A new in_valid during this time is not accepted. Once out_ready=1, the result completes and the next request is accepted in IDLE.
- Reset mid-MUL: assert rst at T+2 -> out_valid=0, busy=0, in_ready=1 after release. The next request a=0x1234, b=0x0010, precise=1 gives 0x00012340.
- Skip feature (macro defined): a=0x0005, b=0x0003, precise=1 -> out_y=15, out_valid at T+2. a=0, b=0x1234 -> out_y=0, out_valid at T+1.
